// File: rtl/timer_periph_pkg.sv
// timer_periph_pkg -- shared peripheral package.
// Holds the timer's bus address map, the TCON bit positions and the
// register-select decode. The CPU-side address decode and the testbench
// import it too, so the map is defined in exactly one place.
package timer_periph_pkg;

  localparam logic [31:0] PERIPH_BASE    = 32'h4000_0000;
  localparam logic [31:0] TH_OFFSET      = 32'h0000_0000;
  localparam logic [31:0] TL_OFFSET      = 32'h0000_0004;
  localparam logic [31:0] TCON_OFFSET    = 32'h0000_0008;
  localparam logic [31:0] SYSTICK_OFFSET = 32'h0000_0014;
  localparam logic [31:0] PSC_OFFSET     = 32'h0000_0018;

  localparam logic [31:0] TH_ADDR      = PERIPH_BASE + TH_OFFSET;
  localparam logic [31:0] TL_ADDR      = PERIPH_BASE + TL_OFFSET;
  localparam logic [31:0] TCON_ADDR    = PERIPH_BASE + TCON_OFFSET;
  localparam logic [31:0] SYSTICK_ADDR = PERIPH_BASE + SYSTICK_OFFSET;
  localparam logic [31:0] PSC_ADDR     = PERIPH_BASE + PSC_OFFSET;

  localparam int TCON_EN_BIT = 0;
  localparam int TCON_IE_BIT = 1;
  localparam int TCON_IF_BIT = 2;

  localparam int PSC_W = 8;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK,
    REG_PSC
  } reg_sel_e;

  // Exact 32-bit match only; PSC decodes only when the prescaler is built.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input bit psc_present);
    reg_sel_e sel;
    sel = REG_NONE;
    case (addr)
      TH_ADDR:      sel = REG_TH;
      TL_ADDR:      sel = REG_TL;
      TCON_ADDR:    sel = REG_TCON;
      SYSTICK_ADDR: sel = REG_SYSTICK;
      PSC_ADDR:     sel = psc_present ? REG_PSC : REG_NONE;
      default:      sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler -- count-tick generator for timer_periph.
// Only built when TIMER_PRESCALE_EN is defined; otherwise this file is empty
// and the timer ticks on every enabled cycle.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   en     : timer enable (TCON.EN); counter holds at 0 while low
//   psc    : prescale value; one tick every psc+1 enabled cycles
//   psc_wr : PSC register write this cycle; restarts the count
//   tick   : count tick, combinational, high for one cycle
`ifdef TIMER_PRESCALE_EN
module timer_prescaler
  import timer_periph_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  input  logic             psc_wr,
  output logic             tick
);

  logic [PSC_W-1:0] cnt_q;

  assign tick = en && (cnt_q == psc);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!en || psc_wr) begin
      cnt_q <= '0;
    end else if (cnt_q == psc) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/timer_periph.sv
// timer_periph -- memory-mapped timer with reload, overflow interrupt and a
// free-running SYSTICK counter.
// Build option: TIMER_PRESCALE_EN adds the PSC register and timer_prescaler.
// Ports:
//   clk    : clock, all state changes on its rising edge
//   reset  : synchronous active-high reset
//   rd     : CPU read strobe; rdata is combinational and 0 when rd=0
//   wr     : CPU write strobe; takes effect at the next rising edge
//   addr   : CPU byte address (exact match decode)
//   wdata  : CPU write data
//   rdata  : read data
//   kernel : high while the CPU runs in kernel mode; masks irq
//   irq    : interrupt request = IF & IE & ~kernel
module timer_periph
  import timer_periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        kernel,
  output logic        irq
);

`ifdef TIMER_PRESCALE_EN
  localparam bit PSC_PRESENT = 1'b1;
`else
  localparam bit PSC_PRESENT = 1'b0;
`endif

  logic [31:0] th_q;
  logic [31:0] tl_q;
  logic [31:0] systick_q;
  logic        en_q;
  logic        ie_q;
  logic        if_q;
  logic        tick;
  logic        overflow;
  logic [31:0] psc_rd;
  reg_sel_e    sel;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;

  assign sel     = decode_addr(addr, PSC_PRESENT);
  assign wr_th   = wr && (sel == REG_TH);
  assign wr_tl   = wr && (sel == REG_TL);
  assign wr_tcon = wr && (sel == REG_TCON);

`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0] psc_q;
  logic             wr_psc;

  assign wr_psc = wr && (sel == REG_PSC);
  assign psc_rd = {{(32-PSC_W){1'b0}}, psc_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      psc_q <= '0;
    end else if (wr_psc) begin
      psc_q <= wdata[PSC_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (en_q),
    .psc    (psc_q),
    .psc_wr (wr_psc),
    .tick   (tick)
  );
`else
  assign psc_rd = '0;
  assign tick   = en_q;
`endif

  assign overflow = tick && (tl_q == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= '0;
      tl_q      <= '0;
      systick_q <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      if_q      <= 1'b0;
    end else begin
      systick_q <= systick_q + 32'd1;

      if (wr_th) begin
        th_q <= wdata;
      end

      // Software write beats the count; overflow reloads from the TH value
      // held before this edge.
      if (wr_tl) begin
        tl_q <= wdata;
      end else if (tick) begin
        tl_q <= overflow ? th_q : tl_q + 32'd1;
      end

      if (wr_tcon) begin
        en_q <= wdata[TCON_EN_BIT];
        ie_q <= wdata[TCON_IE_BIT];
        if_q <= wdata[TCON_IF_BIT];
      end

      // Placed last so a same-cycle TCON clear cannot lose an overflow.
      if (overflow && ie_q) begin
        if_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        REG_TH:      rdata = th_q;
        REG_TL:      rdata = tl_q;
        REG_TCON:    rdata = {29'd0, if_q, ie_q, en_q};
        REG_SYSTICK: rdata = systick_q;
        REG_PSC:     rdata = psc_rd;
        default:     rdata = '0;
      endcase
    end
  end

  assign irq = if_q & ie_q & ~kernel;

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph -- self-checking bench for timer_periph.
// Directed vector table, hand-written reset/prescale sequences, then
// randomized traffic compared against a behavioural model.
module tb_timer_periph;
  import timer_periph_pkg::*;

`ifdef TIMER_PRESCALE_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif
  localparam logic [31:0] EXP_PSC = PSC_ON ? 32'd5 : 32'd0;
  localparam int N_RAND = 3000;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        kernel;
  logic        irq;

  int n_checks;
  int n_errors;

  timer_periph dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .kernel (kernel),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        kernel;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic k, input logic c,
                             input logic [31:0] er, input logic ei, input string n);
    vec_t t;
    t.rd = r; t.wr = w; t.addr = a; t.wdata = d; t.kernel = k;
    t.chk = c; t.exp_rdata = er; t.exp_irq = ei; t.name = n;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the falling edge, settle, caller checks.
  task automatic cyc(input logic rst, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d, input logic k);
    @(negedge clk);
    reset = rst; rd = r; wr = w; addr = a; wdata = d; kernel = k;
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_th, m_tl, m_sys;
  logic        m_en, m_ie, m_if;
  logic [7:0]  m_psc;
  int          m_since;   // enabled cycles since the last tick or restart

  function automatic void model_reset();
    m_th = 0; m_tl = 0; m_sys = 0;
    m_en = 0; m_ie = 0; m_if = 0;
    m_psc = 0; m_since = 0;
  endfunction

  function automatic logic [31:0] model_rdata(input logic r, input logic [31:0] a);
    if (!r) return 32'd0;
    if (a == TH_ADDR)      return m_th;
    if (a == TL_ADDR)      return m_tl;
    if (a == TCON_ADDR)    return {29'd0, m_if, m_ie, m_en};
    if (a == SYSTICK_ADDR) return m_sys;
    if (a == PSC_ADDR && PSC_ON) return {24'd0, m_psc};
    return 32'd0;
  endfunction

  function automatic void model_step(input logic rst, input logic w,
                                     input logic [31:0] a, input logic [31:0] d);
    logic tick, ovf, psc_wr;
    logic [31:0] nxt_tl;
    if (rst) begin
      model_reset();
      return;
    end
    tick   = m_en && (!PSC_ON || (m_since == int'(m_psc)));
    ovf    = tick && (m_tl == 32'hFFFF_FFFF);
    nxt_tl = !tick ? m_tl : (ovf ? m_th : m_tl + 32'd1);
    psc_wr = PSC_ON && w && (a == PSC_ADDR);
    if (!m_en || psc_wr || tick) m_since = 0;
    else                         m_since = m_since + 1;
    if (w && a == TL_ADDR) nxt_tl = d;
    if (w && a == TCON_ADDR) begin
      m_if = d[2];
      if (ovf && m_ie) m_if = 1'b1;
      m_en = d[0];
      m_ie = d[1];
    end else if (ovf && m_ie) begin
      m_if = 1'b1;
    end
    if (w && a == TH_ADDR) m_th = d;
    if (psc_wr) m_psc = d[7:0];
    m_tl  = nxt_tl;
    m_sys = m_sys + 32'd1;
  endfunction

  initial begin
    logic [31:0] ra, rdw, exp_rd;
    logic        rr, rw, rk, rrst;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; kernel = 1'b0;

    // Held in reset: registers and irq read 0.
    cyc(1, 1, 0, SYSTICK_ADDR, 0, 0);
    check("rst_systick", rdata, 32'd0);
    check("rst_irq0", {31'd0, irq}, 32'd0);

    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        0, 1, 32'h0,        0, "tcon_after_rst"));
    vecs.push_back(v(1, 0, SYSTICK_ADDR, 32'h0,        0, 1, 32'h1,        0, "systick_1"));
    vecs.push_back(v(0, 1, TH_ADDR,      32'hFFFFFFF0, 0, 0, 32'h0,        0, "wr_th"));
    vecs.push_back(v(0, 1, TL_ADDR,      32'hFFFFFFFE, 0, 0, 32'h0,        0, "wr_tl"));
    vecs.push_back(v(0, 1, TCON_ADDR,    32'h3,        0, 0, 32'h0,        0, "wr_tcon3"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFFE, 0, "tl_fe"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFFF, 0, "tl_ff"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFF0, 1, "tl_reload_irq"));
    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        1, 1, 32'h7,        0, "kernel_masks"));
    vecs.push_back(v(0, 1, TCON_ADDR,    32'h3,        0, 1, 32'h0,        1, "rd0_zero"));
    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        0, 1, 32'h3,        0, "if_cleared"));
    vecs.push_back(v(0, 1, TL_ADDR,      32'hFFFFFFFF, 0, 0, 32'h0,        0, "wr_tl_ff"));
    vecs.push_back(v(0, 1, TCON_ADDR,    32'h3,        0, 1, 32'h0,        0, "clr_in_ovf"));
    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        0, 1, 32'h7,        1, "if_dominates"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFF1, 1, "tl_after_ovf"));
    vecs.push_back(v(0, 1, TCON_ADDR,    32'h1,        0, 0, 32'h0,        0, "wr_tcon1"));
    vecs.push_back(v(0, 1, TL_ADDR,      32'hFFFFFFFF, 0, 0, 32'h0,        0, "wr_tl_ff2"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFFF, 0, "ie0_tl_ff"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'hFFFFFFF0, 0, "ie0_reload"));
    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        0, 1, 32'h1,        0, "ie0_no_if"));
    vecs.push_back(v(0, 1, TL_ADDR,      32'h100,      0, 0, 32'h0,        0, "wr_tl_100"));
    vecs.push_back(v(1, 0, TL_ADDR,      32'h0,        0, 1, 32'h100,      0, "tl_wr_wins"));
    vecs.push_back(v(0, 1, 32'h4000000C, 32'hFFFFFFFF, 0, 0, 32'h0,        0, "wr_unmapped"));
    vecs.push_back(v(1, 0, 32'h40000020, 32'h0,        0, 1, 32'h0,        0, "rd_unmapped"));
    vecs.push_back(v(1, 0, TCON_ADDR,    32'h0,        0, 1, 32'h1,        0, "unmapped_no_eff"));
    vecs.push_back(v(1, 0, TH_ADDR,      32'h0,        0, 1, 32'hFFFFFFF0, 0, "th_kept"));
    vecs.push_back(v(0, 1, SYSTICK_ADDR, 32'h0,        0, 0, 32'h0,        0, "wr_systick"));
    vecs.push_back(v(1, 0, SYSTICK_ADDR, 32'h0,        0, 1, 32'd27,       0, "systick_ro"));
    vecs.push_back(v(0, 1, PSC_ADDR,     32'h5,        0, 0, 32'h0,        0, "wr_psc"));
    vecs.push_back(v(1, 0, PSC_ADDR,     32'h0,        0, 1, EXP_PSC,      0, "psc_map"));

    foreach (vecs[i]) begin
      cyc(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].kernel);
      if (vecs[i].chk) begin
        check({vecs[i].name, ".rdata"}, rdata, vecs[i].exp_rdata);
        check({vecs[i].name, ".irq"}, {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      end
    end

`ifdef TIMER_PRESCALE_EN
    // PSC=3: one tick every 4 enabled cycles.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, PSC_ADDR, 32'd3, 0);
    cyc(0, 0, 1, TL_ADDR, 32'd0, 0);
    cyc(0, 0, 1, TCON_ADDR, 32'd1, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, TL_ADDR, 0, 0);
    check("psc_tick1", rdata, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, TL_ADDR, 0, 0);
    check("psc_tick2", rdata, 32'd2);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, TL_ADDR, 32'hDEAD, 0);
    cyc(1, 1, 0, PSC_ADDR, 0, 0);
    check("psc_midrst_psc", rdata, 32'd0);
    cyc(1, 1, 0, TL_ADDR, 0, 0);
    check("psc_midrst_tl", rdata, 32'd0);
`endif

    // Reset while irq is up and a TL write is pending.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, TCON_ADDR, 32'd3, 0);
    cyc(0, 0, 1, TL_ADDR, 32'hFFFFFFFF, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, TCON_ADDR, 0, 0);
    check("pre_rst_tcon", rdata, 32'd7);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    cyc(1, 0, 1, TL_ADDR, 32'h1234, 0);
    cyc(1, 1, 0, TH_ADDR, 0, 0);
    check("rst_th", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    cyc(1, 1, 0, TL_ADDR, 0, 0);
    check("rst_tl", rdata, 32'd0);
    cyc(1, 1, 0, TCON_ADDR, 0, 0);
    check("rst_tcon", rdata, 32'd0);
    cyc(1, 1, 0, SYSTICK_ADDR, 0, 0);
    check("rst_systick_hold", rdata, 32'd0);
    cyc(1, 1, 0, PSC_ADDR, 0, 0);
    check("rst_psc", rdata, 32'd0);

    // Randomized traffic against the model; state is reset at this point.
    model_reset();
    for (int n = 0; n < N_RAND; n++) begin
      rrst = ($urandom_range(0, 299) == 0);
      rr   = $urandom_range(0, 1) == 1;
      rw   = $urandom_range(0, 9) < 3;
      rk   = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 7))
        0: ra = TH_ADDR;
        1, 2: ra = TL_ADDR;
        3: ra = TCON_ADDR;
        4: ra = SYSTICK_ADDR;
        5: ra = PSC_ADDR;
        6: ra = 32'h4000000C + 32'($urandom_range(0, 1) * 4);
        default: ra = $urandom;
      endcase
      rdw = $urandom;
      if (ra == TL_ADDR && $urandom_range(0, 1) == 1)
        rdw = 32'hFFFFFFFF - 32'($urandom_range(0, 6));
      if (ra == TCON_ADDR && $urandom_range(0, 3) != 0)
        rdw[0] = 1'b1;
      if (ra == PSC_ADDR)
        rdw[7:0] = 8'($urandom_range(0, 3));
      cyc(rrst, rr, rw, ra, rdw, rk);
      exp_rd = model_rdata(rr, ra);
      check($sformatf("rand%0d.rdata", n), rdata, exp_rd);
      check($sformatf("rand%0d.irq", n), {31'd0, irq}, {31'd0, m_if & m_ie & ~rk});
      model_step(rrst, rw, ra, rdw);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
